// File: rtl/dispatch_pkg.sv
//------------------------------------------------------------------------------
// dispatch_pkg : shared unit encoding, queue-entry layout and default sizes
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dispatch_pkg;

   localparam int DEF_NUM_ALU = 2;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_TAG_W   = 5;
   localparam int DEF_OP_W    = 4;
   localparam int DEF_MUL_LAT = 3;

   // Entry fields are sized for the widest supported build (TAG_W, OP_W <= 8).
   localparam int MAX_TAG_W   = 8;
   localparam int MAX_OP_W    = 8;
   localparam int IMM_W       = 5;

   typedef enum logic [1:0] {
      UNIT_ALU   = 2'd0,
      UNIT_MUL   = 2'd1,
      UNIT_LOAD  = 2'd2,
      UNIT_STORE = 2'd3
   } unit_e;

   typedef struct packed {
      unit_e                unit;
      logic [MAX_OP_W-1:0]  op;
      logic                 imm_sel;
      logic [IMM_W-1:0]     imm;
      logic [MAX_TAG_W-1:0] rs0;
      logic [MAX_TAG_W-1:0] rs1;
      logic [MAX_TAG_W-1:0] rd;
   } entry_t;

endpackage

`default_nettype wire

// File: rtl/dispatch_fifo.sv
//------------------------------------------------------------------------------
// dispatch_fifo : in-order instruction queue, DEPTH entries (power of 2)
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dispatch_fifo
   import dispatch_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   push_i,
   input  entry_t wdata_i,
   input  logic   pop_i,
   output entry_t rdata_o,
   output logic   full_o,
   output logic   empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [CNT_W-1:0] count_q;
   logic             w_push;
   logic             w_pop;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);

   // A full queue refuses pushes even when the head leaves in the same cycle.
   assign w_push  = push_i && !full_o;
   assign w_pop   = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (w_push) wptr_q <= wptr_q + PTR_W'(1);
         if (w_pop)  rptr_q <= rptr_q + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];

endmodule

`default_nettype wire

// File: rtl/dispatch_ctrl.sv
//------------------------------------------------------------------------------
// dispatch_ctrl : in-order dispatch with tag scoreboard, ALU/MUL/LS issue
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dispatch_ctrl
   import dispatch_pkg::*;
#(
   parameter int NUM_ALU = DEF_NUM_ALU,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int TAG_W   = DEF_TAG_W,
   parameter int OP_W    = DEF_OP_W,
   parameter int MUL_LAT = DEF_MUL_LAT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [1:0]                   in_unit,
   input  logic [OP_W-1:0]              in_op,
   input  logic                         in_imm_sel,
   input  logic [4:0]                   in_imm,
   input  logic [TAG_W-1:0]             in_rs0_tag,
   input  logic [TAG_W-1:0]             in_rs1_tag,
   input  logic [TAG_W-1:0]             in_rd_tag,
   input  logic [NUM_ALU-1:0]           alu_ready,
   input  logic                         ls_ready,
   output logic [NUM_ALU-1:0]           alu_valid,
   output logic [NUM_ALU*OP_W-1:0]      alu_op,
   output logic [NUM_ALU-1:0]           alu_imm_sel,
   output logic [NUM_ALU*5-1:0]         alu_imm,
   output logic [NUM_ALU*TAG_W-1:0]     alu_rd_tag,
   output logic                         mul_valid,
   output logic                         mul_imm_sel,
   output logic [4:0]                   mul_imm,
   output logic [TAG_W-1:0]             mul_rd_tag,
   output logic                         ls_valid,
   output logic                         ls_store,
   output logic [TAG_W-1:0]             ls_rd_tag,
   input  logic [NUM_ALU+1:0]           wb_valid,
   input  logic [(NUM_ALU+2)*TAG_W-1:0] wb_tag,
   output logic                         err
);

   localparam int NTAGS = 2 ** TAG_W;
   localparam int NWB   = NUM_ALU + 2;
   localparam int MCW   = $clog2(MUL_LAT + 1);

   entry_t w_in_entry;
   entry_t w_head;
   logic   w_full;
   logic   w_empty;
   logic   w_issue;

   logic [NTAGS-1:0]         pending_q, pending_d;
   logic [MCW-1:0]           mul_cnt_q, mul_cnt_d;
   logic                     err_q, err_d;
   logic [NUM_ALU-1:0]       alu_valid_q, alu_valid_d;
   logic [NUM_ALU*OP_W-1:0]  alu_op_q, alu_op_d;
   logic [NUM_ALU-1:0]       alu_imm_sel_q, alu_imm_sel_d;
   logic [NUM_ALU*5-1:0]     alu_imm_q, alu_imm_d;
   logic [NUM_ALU*TAG_W-1:0] alu_rd_tag_q, alu_rd_tag_d;
   logic                     mul_valid_q, mul_valid_d;
   logic                     mul_imm_sel_q, mul_imm_sel_d;
   logic [4:0]               mul_imm_q, mul_imm_d;
   logic [TAG_W-1:0]         mul_rd_tag_q, mul_rd_tag_d;
   logic                     ls_valid_q, ls_valid_d;
   logic                     ls_store_q, ls_store_d;
   logic [TAG_W-1:0]         ls_rd_tag_q, ls_rd_tag_d;

   logic [NTAGS-1:0]   w_wb_hit;
   logic [NTAGS-1:0]   w_set;
   logic [TAG_W-1:0]   w_rs0, w_rs1, w_rd;
   logic [NUM_ALU-1:0] w_alu_sel;
   logic               w_is_store, w_pad_ok, w_rs0_ok, w_rs1_ok, w_waw_ok, w_res_ok;

   always_comb begin
      w_in_entry         = '0;
      w_in_entry.unit    = unit_e'(in_unit);
      w_in_entry.op      = MAX_OP_W'(in_op);
      w_in_entry.imm_sel = in_imm_sel;
      w_in_entry.imm     = in_imm;
      w_in_entry.rs0     = MAX_TAG_W'(in_rs0_tag);
      w_in_entry.rs1     = MAX_TAG_W'(in_rs1_tag);
      w_in_entry.rd      = MAX_TAG_W'(in_rd_tag);
   end

   dispatch_fifo #(
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (in_valid),
      .wdata_i (w_in_entry),
      .pop_i   (w_issue),
      .rdata_o (w_head),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   assign in_ready = !w_full;

   always_comb begin
      w_wb_hit = '0;
      for (int k = 0; k < NWB; k++) begin
         if (wb_valid[k]) w_wb_hit[wb_tag[k*TAG_W +: TAG_W]] = 1'b1;
      end
      w_wb_hit[0] = 1'b0;
   end

   assign w_rs0      = w_head.rs0[TAG_W-1:0];
   assign w_rs1      = w_head.rs1[TAG_W-1:0];
   assign w_rd       = w_head.rd[TAG_W-1:0];
   assign w_is_store = (w_head.unit == UNIT_STORE);

   // Pad bits above TAG_W/OP_W are always written zero; nonzero means corrupt storage.
   assign w_pad_ok = ((w_head.op  >> OP_W)  == '0) && ((w_head.rs0 >> TAG_W) == '0) &&
                     ((w_head.rs1 >> TAG_W) == '0) && ((w_head.rd  >> TAG_W) == '0);

   assign w_rs0_ok  = !pending_q[w_rs0] || w_wb_hit[w_rs0];
   assign w_rs1_ok  = w_head.imm_sel || !pending_q[w_rs1] || w_wb_hit[w_rs1];
   assign w_waw_ok  = w_is_store || (w_rd == '0) || !pending_q[w_rd] || w_wb_hit[w_rd];
   assign w_alu_sel = alu_ready & (~alu_ready + NUM_ALU'(1));

   always_comb begin
      unique case (w_head.unit)
         UNIT_ALU: w_res_ok = |alu_ready;
         UNIT_MUL: w_res_ok = (mul_cnt_q == '0);
         default:  w_res_ok = ls_ready;
      endcase
   end

   assign w_issue = !w_empty && w_pad_ok && w_rs0_ok && w_rs1_ok && w_waw_ok && w_res_ok;

   always_comb begin
      w_set = '0;
      if (w_issue && !w_is_store && (w_rd != '0)) w_set[w_rd] = 1'b1;

      // Set wins over a same-cycle clear of the same tag.
      pending_d    = (pending_q & ~w_wb_hit) | w_set;
      pending_d[0] = 1'b0;
      err_d        = err_q | (|(w_wb_hit & ~pending_q & ~w_set));

      mul_cnt_d = (mul_cnt_q != '0) ? mul_cnt_q - MCW'(1) : mul_cnt_q;

      alu_valid_d   = '0;
      alu_op_d      = alu_op_q;
      alu_imm_sel_d = alu_imm_sel_q;
      alu_imm_d     = alu_imm_q;
      alu_rd_tag_d  = alu_rd_tag_q;
      mul_valid_d   = 1'b0;
      mul_imm_sel_d = mul_imm_sel_q;
      mul_imm_d     = mul_imm_q;
      mul_rd_tag_d  = mul_rd_tag_q;
      ls_valid_d    = 1'b0;
      ls_store_d    = ls_store_q;
      ls_rd_tag_d   = ls_rd_tag_q;

      if (w_issue) begin
         unique case (w_head.unit)
            UNIT_ALU: begin
               alu_valid_d = w_alu_sel;
               for (int c = 0; c < NUM_ALU; c++) begin
                  if (w_alu_sel[c]) begin
                     alu_op_d[c*OP_W +: OP_W]     = w_head.op[OP_W-1:0];
                     alu_imm_sel_d[c]             = w_head.imm_sel;
                     alu_imm_d[c*5 +: 5]          = w_head.imm;
                     alu_rd_tag_d[c*TAG_W +: TAG_W] = w_rd;
                  end
               end
            end
            UNIT_MUL: begin
               mul_valid_d   = 1'b1;
               mul_imm_sel_d = w_head.imm_sel;
               mul_imm_d     = w_head.imm;
               mul_rd_tag_d  = w_rd;
               mul_cnt_d     = MCW'(MUL_LAT - 1);
            end
            default: begin
               ls_valid_d  = 1'b1;
               ls_store_d  = w_is_store;
               ls_rd_tag_d = w_is_store ? '0 : w_rd;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q     <= '0;
         mul_cnt_q     <= '0;
         err_q         <= 1'b0;
         alu_valid_q   <= '0;
         alu_op_q      <= '0;
         alu_imm_sel_q <= '0;
         alu_imm_q     <= '0;
         alu_rd_tag_q  <= '0;
         mul_valid_q   <= 1'b0;
         mul_imm_sel_q <= 1'b0;
         mul_imm_q     <= '0;
         mul_rd_tag_q  <= '0;
         ls_valid_q    <= 1'b0;
         ls_store_q    <= 1'b0;
         ls_rd_tag_q   <= '0;
      end else begin
         pending_q     <= pending_d;
         mul_cnt_q     <= mul_cnt_d;
         err_q         <= err_d;
         alu_valid_q   <= alu_valid_d;
         alu_op_q      <= alu_op_d;
         alu_imm_sel_q <= alu_imm_sel_d;
         alu_imm_q     <= alu_imm_d;
         alu_rd_tag_q  <= alu_rd_tag_d;
         mul_valid_q   <= mul_valid_d;
         mul_imm_sel_q <= mul_imm_sel_d;
         mul_imm_q     <= mul_imm_d;
         mul_rd_tag_q  <= mul_rd_tag_d;
         ls_valid_q    <= ls_valid_d;
         ls_store_q    <= ls_store_d;
         ls_rd_tag_q   <= ls_rd_tag_d;
      end
   end

   assign alu_valid   = alu_valid_q;
   assign alu_op      = alu_op_q;
   assign alu_imm_sel = alu_imm_sel_q;
   assign alu_imm     = alu_imm_q;
   assign alu_rd_tag  = alu_rd_tag_q;
   assign mul_valid   = mul_valid_q;
   assign mul_imm_sel = mul_imm_sel_q;
   assign mul_imm     = mul_imm_q;
   assign mul_rd_tag  = mul_rd_tag_q;
   assign ls_valid    = ls_valid_q;
   assign ls_store    = ls_store_q;
   assign ls_rd_tag   = ls_rd_tag_q;
   assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
//------------------------------------------------------------------------------
// tb_dispatch_ctrl : directed self-checking bench for dispatch_ctrl
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dispatch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_unit;
   logic [3:0]  in_op;
   logic        in_imm_sel;
   logic [4:0]  in_imm;
   logic [4:0]  in_rs0_tag, in_rs1_tag, in_rd_tag;
   logic [1:0]  alu_ready;
   logic        ls_ready;
   logic [1:0]  alu_valid;
   logic [7:0]  alu_op;
   logic [1:0]  alu_imm_sel;
   logic [9:0]  alu_imm;
   logic [9:0]  alu_rd_tag;
   logic        mul_valid;
   logic        mul_imm_sel;
   logic [4:0]  mul_imm;
   logic [4:0]  mul_rd_tag;
   logic        ls_valid;
   logic        ls_store;
   logic [4:0]  ls_rd_tag;
   logic [3:0]  wb_valid;
   logic [19:0] wb_tag;
   logic        err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dispatch_ctrl #(
      .NUM_ALU (2), .DEPTH (4), .TAG_W (5), .OP_W (4), .MUL_LAT (3)
   ) dut (
      .clk (clk), .rst (rst),
      .in_valid (in_valid), .in_ready (in_ready), .in_unit (in_unit), .in_op (in_op),
      .in_imm_sel (in_imm_sel), .in_imm (in_imm),
      .in_rs0_tag (in_rs0_tag), .in_rs1_tag (in_rs1_tag), .in_rd_tag (in_rd_tag),
      .alu_ready (alu_ready), .ls_ready (ls_ready),
      .alu_valid (alu_valid), .alu_op (alu_op), .alu_imm_sel (alu_imm_sel),
      .alu_imm (alu_imm), .alu_rd_tag (alu_rd_tag),
      .mul_valid (mul_valid), .mul_imm_sel (mul_imm_sel), .mul_imm (mul_imm),
      .mul_rd_tag (mul_rd_tag),
      .ls_valid (ls_valid), .ls_store (ls_store), .ls_rd_tag (ls_rd_tag),
      .wb_valid (wb_valid), .wb_tag (wb_tag), .err (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] u, input logic [3:0] op, input logic isel,
                       input logic [4:0] imm, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [4:0] rd);
      in_valid   = 1'b1;
      in_unit    = u;
      in_op      = op;
      in_imm_sel = isel;
      in_imm     = imm;
      in_rs0_tag = rs0;
      in_rs1_tag = rs1;
      in_rd_tag  = rd;
   endtask

   task automatic wb(input logic [3:0] v, input logic [19:0] t);
      wb_valid = v;
      wb_tag   = t;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_unit = 2'd0; in_op = 4'd0; in_imm_sel = 1'b0;
      in_imm = 5'd0; in_rs0_tag = 5'd0; in_rs1_tag = 5'd0; in_rd_tag = 5'd0;
      alu_ready = 2'b00; ls_ready = 1'b0; wb_valid = 4'b0; wb_tag = 20'd0;
      step(); step();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_alu_valid", 32'(alu_valid), 32'd0);
      chk("rst_mul_valid", 32'(mul_valid), 32'd0);
      chk("rst_ls_valid", 32'(ls_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_alu_rd", 32'(alu_rd_tag), 32'd0);
      rst = 1'b0;

      // ALU rd=3 into empty queue, both channels free -> channel 0 next cycle
      alu_ready = 2'b11;
      push(2'd0, 4'd5, 1'b0, 5'd0, 5'd0, 5'd0, 5'd3);
      step();
      in_valid = 1'b0;
      chk("alu1_not_yet", 32'(alu_valid), 32'd0);
      step();
      chk("alu1_valid", 32'(alu_valid), 32'b01);
      chk("alu1_op", 32'(alu_op[3:0]), 32'd5);
      chk("alu1_rd", 32'(alu_rd_tag[4:0]), 32'd3);
      step();
      chk("alu1_one_shot", 32'(alu_valid), 32'd0);
      // tag 3 pending -> its writeback is legal
      wb(4'b0001, 20'd3);
      step();
      wb(4'b0000, 20'd0);
      chk("wb3_no_err", 32'(err), 32'd0);

      // dependent pair on channel 1 with writeback bypass
      alu_ready = 2'b10;
      push(2'd0, 4'd1, 1'b0, 5'd0, 5'd0, 5'd0, 5'd3);
      step();
      push(2'd0, 4'd2, 1'b0, 5'd0, 5'd3, 5'd0, 5'd4);
      step();
      in_valid = 1'b0;
      chk("dep_a_valid", 32'(alu_valid), 32'b10);
      chk("dep_a_rd", 32'(alu_rd_tag[9:5]), 32'd3);
      step();
      chk("dep_b_wait1", 32'(alu_valid), 32'd0);
      step();
      chk("dep_b_wait2", 32'(alu_valid), 32'd0);
      wb(4'b0001, 20'd3);
      step();
      wb(4'b0000, 20'd0);
      chk("dep_b_bypass", 32'(alu_valid), 32'b10);
      chk("dep_b_rd", 32'(alu_rd_tag[9:5]), 32'd4);
      chk("dep_b_op", 32'(alu_op[7:4]), 32'd2);
      chk("dep_b_err", 32'(err), 32'd0);

      // three independent MULs, interval 3
      push(2'd1, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd5);
      wb(4'b0001, 20'd4);
      step();
      wb(4'b0000, 20'd0);
      push(2'd1, 4'd0, 1'b1, 5'd9, 5'd0, 5'd0, 5'd6);
      step();
      chk("mul_c1", 32'(mul_valid), 32'd1);
      chk("mul_c1_rd", 32'(mul_rd_tag), 32'd5);
      push(2'd1, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd7);
      step();
      in_valid = 1'b0;
      chk("mul_c2", 32'(mul_valid), 32'd0);
      step();
      chk("mul_c3", 32'(mul_valid), 32'd0);
      step();
      chk("mul_c4", 32'(mul_valid), 32'd1);
      chk("mul_c4_rd", 32'(mul_rd_tag), 32'd6);
      chk("mul_c4_imm", 32'({mul_imm_sel, mul_imm}), 32'({1'b1, 5'd9}));
      step();
      chk("mul_c5", 32'(mul_valid), 32'd0);
      step();
      chk("mul_c6", 32'(mul_valid), 32'd0);
      step();
      chk("mul_c7", 32'(mul_valid), 32'd1);
      chk("mul_c7_rd", 32'(mul_rd_tag), 32'd7);
      wb(4'b0111, {5'd0, 5'd7, 5'd6, 5'd5});
      step();
      wb(4'b0000, 20'd0);
      chk("mul_wb_err", 32'(err), 32'd0);

      // fill the queue with loads while LS is busy
      ls_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push(2'd2, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'(10 + i));
         step();
      end
      chk("full_ready", 32'(in_ready), 32'd0);
      push(2'd2, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd14);
      step();
      chk("full_hold", 32'(in_ready), 32'd0);
      ls_ready = 1'b1;
      step();
      ls_ready = 1'b0;
      chk("ld_pop_valid", 32'(ls_valid), 32'd1);
      chk("ld_pop_store", 32'(ls_store), 32'd0);
      chk("ld_pop_rd", 32'(ls_rd_tag), 32'd10);
      chk("ready_back", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("refill_full", 32'(in_ready), 32'd0);
      ls_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("drain_rd", 32'(ls_rd_tag), 32'(11 + i));
      end
      ls_ready = 1'b0;
      step();
      chk("drain_idle", 32'(ls_valid), 32'd0);

      // reset mid-operation discards queue and scoreboard
      push(2'd2, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd16);
      step();
      push(2'd2, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd17);
      step();
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      ls_ready = 1'b1;
      step();
      chk("mid_rst_no_issue1", 32'(ls_valid), 32'd0);
      step();
      chk("mid_rst_no_issue2", 32'(ls_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      wb(4'b1000, {5'd10, 15'd0});
      step();
      wb(4'b0000, 20'd0);
      chk("stale_wb_err", 32'(err), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("err_clr", 32'(err), 32'd0);

      // writeback of a never-issued tag is sticky until reset
      wb(4'b0010, {10'd0, 5'd9, 5'd0});
      step();
      wb(4'b0000, 20'd0);
      chk("tag9_err", 32'(err), 32'd1);
      step(); step();
      chk("tag9_err_held", 32'(err), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("tag9_rst_err", 32'(err), 32'd0);
      chk("tag9_rst_ready", 32'(in_ready), 32'd1);

      // STORE issues on LS and sets no pending tag
      ls_ready = 1'b1;
      push(2'd3, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd15);
      step();
      in_valid = 1'b0;
      step();
      chk("st_valid", 32'(ls_valid), 32'd1);
      chk("st_store", 32'(ls_store), 32'd1);
      chk("st_err", 32'(err), 32'd0);
      wb(4'b1000, {5'd15, 15'd0});
      step();
      wb(4'b0000, 20'd0);
      chk("st_no_pending", 32'(err), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
